// File: rtl/bicubic_win_sched_pkg.sv
// Shared definitions for the bicubic window scheduler: state encodings,
// the default response count and the prime-count helper.
package bicubic_win_sched_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRIME = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_RSP   = 3'd3;
  localparam logic [2:0] ST_ADV   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int RSP_PER_WIN_DEF = 4;

  // Shifts needed before the first 4x4 window is complete: three full lines plus four taps.
  function automatic int prime_count(input int w);
    return 3 * w + 4;
  endfunction

endpackage

// File: rtl/bicubic_win_sched_dncnt.sv
// Loadable down-counter with enable; flags the count that the next enabled step takes to zero.
module bicubic_win_sched_dncnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/bicubic_win_sched.sv
// Window scheduler for the bicubic path: primes the 4x4 window buffer, issues one
// request per valid window, collects the core responses and skips row-wrap windows.
module bicubic_win_sched
  import bicubic_win_sched_pkg::*;
#(
  parameter int IMG_W       = 960,
  parameter int IMG_H       = 540,
  parameter int RSP_PER_WIN = RSP_PER_WIN_DEF,
  parameter int CW          = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  input  logic          src_valid,
  output logic          src_ready,
  output logic          shift_en,
  output logic          win_valid,
  input  logic          win_ready,
  input  logic          rsp_valid,
  output logic          rsp_ready,
  output logic [CW-1:0] win_col,
  output logic [CW-1:0] win_row,
  output logic [1:0]    rsp_idx
);

  localparam int              PW       = $clog2(3 * IMG_W + 5);
  localparam logic [PW-1:0]   PRIME_LD = PW'(prime_count(IMG_W));
  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 4);
  localparam logic [CW-1:0]   ROW_LAST = CW'(IMG_H - 4);
  localparam logic [1:0]      IDX_LAST = 2'(RSP_PER_WIN - 1);

  logic [2:0] state, state_nx;
  logic       idle_start, rsp_hs, win_last_rsp, row_end, frame_end;
  logic       prime_last, adv_last;

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign src_ready  = (state == ST_PRIME) || (state == ST_ADV);
  assign win_valid  = (state == ST_REQ);
  assign rsp_ready  = (state == ST_RSP);
  assign shift_en   = src_valid & src_ready;

  assign idle_start   = (state == ST_IDLE) && start;
  assign rsp_hs       = rsp_valid & rsp_ready;
  assign win_last_rsp = rsp_hs && (rsp_idx == IDX_LAST);
  assign row_end      = (win_col == COL_LAST);
  assign frame_end    = row_end && (win_row == ROW_LAST);

  bicubic_win_sched_dncnt #(.W(PW)) u_prime_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (idle_start),
    .en       (shift_en && state == ST_PRIME),
    .load_val (PRIME_LD),
    .last     (prime_last)
  );

  // Row end needs four shifts: three pass through wrap windows that are never requested.
  bicubic_win_sched_dncnt #(.W(3)) u_adv_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (win_last_rsp && !frame_end),
    .en       (shift_en && state == ST_ADV),
    .load_val (row_end ? 3'd4 : 3'd1),
    .last     (adv_last)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_PRIME;
      ST_PRIME: if (shift_en && prime_last) state_nx = ST_REQ;
      ST_REQ:   if (win_ready) state_nx = ST_RSP;
      ST_RSP:   if (win_last_rsp) state_nx = frame_end ? ST_DONE : ST_ADV;
      ST_ADV:   if (shift_en && adv_last) state_nx = ST_REQ;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_col <= '0;
      win_row <= '0;
    end else if (idle_start) begin
      win_col <= '0;
      win_row <= '0;
    end else if (win_last_rsp && !frame_end) begin
      if (row_end) begin
        win_col <= '0;
        win_row <= win_row + 1'b1;
      end else begin
        win_col <= win_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rsp_idx <= '0;
    else if (idle_start) rsp_idx <= '0;
    else if (rsp_hs)     rsp_idx <= (rsp_idx == IDX_LAST) ? 2'd0 : rsp_idx + 2'd1;
  end

endmodule

// File: tb/tb_bicubic_win_sched.sv
// Self-checking bench for bicubic_win_sched: frame-level reference model of windows,
// shift gaps and response counts, with random handshake stalls.
module tb_bicubic_win_sched;

  localparam int W  = 11;
  localparam int H  = 6;
  localparam int R  = 4;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst_n, start, src_valid, win_ready, rsp_valid;

  logic          busy, frame_done, src_ready, shift_en, win_valid, rsp_ready;
  logic [CW-1:0] win_col, win_row;
  logic [1:0]    rsp_idx;

  logic          s_busy, s_frame_done, s_src_ready, s_shift_en, s_win_valid, s_rsp_ready;
  logic [CW-1:0] s_win_col, s_win_row;
  logic [1:0]    s_rsp_idx;

  bicubic_win_sched #(.IMG_W(W), .IMG_H(H), .RSP_PER_WIN(R), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .src_valid(src_valid), .src_ready(src_ready), .shift_en(shift_en),
    .win_valid(win_valid), .win_ready(win_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .win_col(win_col), .win_row(win_row), .rsp_idx(rsp_idx)
  );

  bicubic_win_sched #(.IMG_W(4), .IMG_H(4), .RSP_PER_WIN(R), .CW(CW)) dut_min (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(s_busy), .frame_done(s_frame_done),
    .src_valid(src_valid), .src_ready(s_src_ready), .shift_en(s_shift_en),
    .win_valid(s_win_valid), .win_ready(win_ready), .rsp_valid(rsp_valid),
    .rsp_ready(s_rsp_ready), .win_col(s_win_col), .win_row(s_win_row), .rsp_idx(s_rsp_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_shift, n_win, n_rsp, n_done, n_bad, first_rdy, done_cyc;
  logic busy_after;
  int win_q[$];
  int gap_q[$];
  int exp_win_q[$];
  int exp_gap_q[$];

  // Reference: windows in raster order over valid positions; gaps are the shifts before each.
  task automatic build_model();
    exp_win_q = {};
    exp_gap_q = {};
    for (int r = 0; r <= H - 4; r++)
      for (int c = 0; c <= W - 4; c++) begin
        exp_win_q.push_back(r * 256 + c);
        if (r == 0 && c == 0) exp_gap_q.push_back(3 * W + 4);
        else if (c == 0)      exp_gap_q.push_back(4);
        else                  exp_gap_q.push_back(1);
      end
  endtask

  task automatic idle_inputs();
    start = 1'b0; src_valid = 1'b0; win_ready = 1'b0; rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one frame on the main instance and records what it observes.
  task automatic drive_frame(input bit stall, input bit poke, input int abort_win);
    int  gap = 0, in_win = 0;
    bit  prev_stall = 1'b0, prev_hs = 1'b0, saw_done = 1'b0, quit = 1'b0;
    n_shift = 0; n_win = 0; n_rsp = 0; n_done = 0; n_bad = 0;
    first_rdy = -1; done_cyc = -1; busy_after = 1'bx;
    win_q = {}; gap_q = {};
    for (int cyc = 0; cyc < 20000 && !quit; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) ||
              (poke && ((n_win == 0 && n_shift == 10) || (n_win == 5 && rsp_ready)));
      src_valid = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      win_ready = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      rsp_valid = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      if (saw_done) begin
        busy_after = busy;
        quit = 1'b1;
      end else begin
        if (first_rdy < 0 && src_ready) first_rdy = cyc;
        if (int'(src_ready) + int'(win_valid) + int'(rsp_ready) > 1) n_bad++;
        if (shift_en !== (src_valid & src_ready)) n_bad++;
        if (prev_hs && !rsp_ready) n_bad++;
        if (prev_stall && !win_valid) n_bad++;
        if (shift_en) begin n_shift++; gap++; end
        if (win_valid && win_ready) begin
          win_q.push_back(int'(win_row) * 256 + int'(win_col));
          gap_q.push_back(gap);
          if (in_win != 0) n_bad++;
          gap = 0;
          n_win++;
        end
        if (rsp_valid && rsp_ready) begin
          if (int'(rsp_idx) != in_win) n_bad++;
          in_win = (in_win == R - 1) ? 0 : in_win + 1;
          n_rsp++;
        end
        if (frame_done) begin
          n_done++;
          done_cyc = cyc;
          saw_done = 1'b1;
        end
        if (abort_win >= 0 && n_win == abort_win + 1 && rsp_ready) quit = 1'b1;
        prev_stall = win_valid && !win_ready;
        prev_hs    = win_valid && win_ready;
      end
    end
    if (!quit) n_bad++;
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, src_ready, shift_en, win_valid, rsp_ready, win_col, win_row, rsp_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
               {busy, frame_done, src_ready, shift_en, win_valid, rsp_ready, win_col, win_row, rsp_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    do_reset();
    drive_frame(1'b0, 1'b0, -1);
    checks++; if (first_rdy !== 1)  begin errors++; $display("FAIL start_latency got %0d required 1", first_rdy); end
    checks++; if (gap_q.size() == 0 || gap_q[0] !== 3 * W + 4)
      begin errors++; $display("FAIL prime_shifts got %0d required %0d", gap_q.size() ? gap_q[0] : -1, 3 * W + 4); end
    checks++; if (n_win !== 24)     begin errors++; $display("FAIL nom_windows got %0d required 24", n_win); end
    checks++; if (n_rsp !== 96)     begin errors++; $display("FAIL nom_responses got %0d required 96", n_rsp); end
    checks++; if (n_shift !== 66)   begin errors++; $display("FAIL nom_shifts got %0d required 66", n_shift); end
    checks++; if (n_done !== 1)     begin errors++; $display("FAIL nom_done_pulses got %0d required 1", n_done); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL nom_busy_after_done got %b required 0", busy_after); end
    checks++; if (done_cyc !== 187) begin errors++; $display("FAIL nom_frame_cycles got %0d required 187", done_cyc); end
    checks++; if (win_q != exp_win_q) begin errors++; $display("FAIL nom_coord_seq got %p required %p", win_q, exp_win_q); end
    checks++; if (n_bad !== 0)      begin errors++; $display("FAIL nom_protocol got %0d required 0", n_bad); end
  endtask

  task automatic test_row_wrap();
    do_reset();
    drive_frame(1'b0, 1'b0, -1);
    checks++;
    if (win_q.size() < 9 || win_q[7] !== 7 || win_q[8] !== 256 || gap_q[8] !== 4) begin
      errors++;
      $display("FAIL row_wrap got win7=%0h win8=%0h gap=%0d required 7 100 4",
               win_q.size() > 8 ? win_q[7] : -1, win_q.size() > 8 ? win_q[8] : -1,
               win_q.size() > 8 ? gap_q[8] : -1);
    end
    checks++; if (gap_q != exp_gap_q) begin errors++; $display("FAIL gap_seq got %p required %p", gap_q, exp_gap_q); end
  endtask

  task automatic test_stalls();
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      drive_frame(1'b1, 1'b0, -1);
      checks++; if (n_shift !== W * H) begin errors++; $display("FAIL stall_shifts got %0d required %0d", n_shift, W * H); end
      checks++; if (n_rsp !== R * 24)  begin errors++; $display("FAIL stall_responses got %0d required %0d", n_rsp, R * 24); end
      checks++; if (win_q != exp_win_q || gap_q != exp_gap_q)
        begin errors++; $display("FAIL stall_coord_seq got %p required %p", win_q, exp_win_q); end
      checks++; if (n_done !== 1 || busy_after !== 1'b0)
        begin errors++; $display("FAIL stall_done got %0d/%b required 1/0", n_done, busy_after); end
      checks++; if (n_bad !== 0) begin errors++; $display("FAIL stall_protocol got %0d required 0", n_bad); end
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    drive_frame(1'b0, 1'b1, -1);
    checks++; if (n_shift !== 66) begin errors++; $display("FAIL poke_shifts got %0d required 66", n_shift); end
    checks++; if (n_win !== 24 || n_done !== 1)
      begin errors++; $display("FAIL poke_frame got win=%0d done=%0d required 24 1", n_win, n_done); end
    checks++; if (win_q != exp_win_q) begin errors++; $display("FAIL poke_coord_seq got %p required %p", win_q, exp_win_q); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_frame(1'b0, 1'b0, 11);
    checks++;
    if (win_q.size() != 12 || win_q[11] !== 256 + 3 || rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_reach got n=%0d rsp_ready=%b required 12 1", win_q.size(), rsp_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, src_ready, shift_en, win_valid, rsp_ready, win_col, win_row, rsp_idx} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got %h required 0",
               {busy, frame_done, src_ready, shift_en, win_valid, rsp_ready, win_col, win_row, rsp_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_frame(1'b0, 1'b0, -1);
    checks++;
    if (gap_q.size() == 0 || gap_q[0] !== 37 || win_q[0] !== 0) begin
      errors++;
      $display("FAIL midrst_reprime got gap=%0d win=%0h required 37 0",
               gap_q.size() ? gap_q[0] : -1, win_q.size() ? win_q[0] : -1);
    end
    checks++; if (n_shift !== 66 || n_done !== 1)
      begin errors++; $display("FAIL midrst_frame got shifts=%0d done=%0d required 66 1", n_shift, n_done); end
  endtask

  task automatic test_min_size();
    int sh = 0, wn = 0, rs = 0, dn = 0, adv = 0;
    bit fin = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      start = (cyc == 0);
      src_valid = 1'b1; win_ready = 1'b1; rsp_valid = 1'b1;
      #1;
      if (s_shift_en) sh++;
      if (s_src_ready && wn > 0) adv++;
      if (s_win_valid && win_ready) wn++;
      if (s_rsp_ready && rsp_valid) rs++;
      if (s_frame_done) begin dn++; fin = 1'b1; end
    end
    idle_inputs();
    checks++; if (sh !== 16) begin errors++; $display("FAIL min_shifts got %0d required 16", sh); end
    checks++; if (wn !== 1 || rs !== 4)
      begin errors++; $display("FAIL min_win_rsp got %0d/%0d required 1/4", wn, rs); end
    checks++; if (dn !== 1 || adv !== 0)
      begin errors++; $display("FAIL min_done_noadv got %0d/%0d required 1/0", dn, adv); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    build_model();
    test_reset();
    test_nominal();
    test_row_wrap();
    test_stalls();
    test_start_ignored();
    test_reset_mid();
    test_min_size();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
